// File: rtl/io_reg_injector.sv
// Regfile write-port injector: queues external register writes and slips them into
// processor-idle cycles so processor writes are never delayed or lost.
module io_reg_injector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_reg,
    input  logic [31:0]   req_data,
    input  logic          cpu_we,
    input  logic [4:0]    cpu_rd,
    input  logic [31:0]   cpu_data,
    output logic          rf_we,
    output logic [4:0]    rf_rd,
    output logic [31:0]   rf_data,
    output logic          inj_active,
    output logic          dropped,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_reset_done;
    logic          r_dropped;

    logic          w_pop;
    logic          w_accept;
    logic          w_drop;
    logic          w_match;
    logic          w_alloc;
    logic          w_coalesce;
    logic [PW-1:0] w_match_idx;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_off;

    assign req_ready  = (r_count < CW'(DEPTH)) && r_reset_done;
    // Injection is suppressed while reset is held so a queue being flushed never leaks a write.
    assign w_pop      = reset && !cpu_we && (r_count != '0);
    assign w_accept   = req_valid && req_ready;
    assign w_drop     = w_accept && (req_reg == 5'd0);
    assign w_coalesce = w_accept && !w_drop && w_match;
    assign w_alloc    = w_accept && !w_drop && !w_match;

    // The head leaving this edge is not a coalesce target; the request gets a fresh tail slot.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_idx       = '0;
        w_off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = PW'(i);
            w_off = w_idx - r_rptr;
            if ((CW'(w_off) < r_count) && (r_reg[w_idx] == req_reg)
                && !(w_pop && (w_idx == r_rptr))) begin
                w_match     = 1'b1;
                w_match_idx = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rptr       <= '0;
            r_wptr       <= '0;
            r_count      <= '0;
            r_reset_done <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_reset_done <= 1'b1;
            r_dropped    <= w_drop;
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_alloc) begin
                r_wptr <= r_wptr + PW'(1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_reg[r_wptr]  <= req_reg;
            r_data[r_wptr] <= req_data;
        end else if (w_coalesce) begin
            r_data[w_match_idx] <= req_data;
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_rd      = 5'd0;
        rf_data    = 32'd0;
        inj_active = 1'b0;
        if (cpu_we) begin
            rf_we   = 1'b1;
            rf_rd   = cpu_rd;
            rf_data = cpu_data;
        end else if (w_pop) begin
            rf_we      = 1'b1;
            rf_rd      = r_reg[r_rptr];
            rf_data    = r_data[r_rptr];
            inj_active = 1'b1;
        end
    end

    assign count   = r_count;
    assign dropped = r_dropped;

endmodule

// File: tb/tb_io_reg_injector.sv
// Randomized bench for io_reg_injector: a queue-based model predicts every output each cycle,
// and a few directed scenarios pin the model with literal values.
module tb_io_reg_injector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_reg;
    logic [31:0]   req_data;
    logic          cpu_we;
    logic [4:0]    cpu_rd;
    logic [31:0]   cpu_data;
    logic          rf_we;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_data;
    logic          inj_active;
    logic          dropped;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    io_reg_injector #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .cpu_we     (cpu_we),
        .cpu_rd     (cpu_rd),
        .cpu_data   (cpu_data),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .inj_active (inj_active),
        .dropped    (dropped),
        .count      (count)
    );

    always #5 clock = ~clock;

    // Reference model: pending injections as an ordered list of (register, value).
    int unsigned m_reg[$];
    logic [31:0] m_data[$];
    bit          m_done    = 0;
    bit          m_dropped = 0;
    bit          m_valid   = 0;
    bit          m_acc;
    bit          m_found;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_reg.delete();
            m_data.delete();
            m_done    = 0;
            m_dropped = 0;
            m_valid   = 1;
        end else if (m_valid) begin
            m_acc = req_valid && m_done && (m_reg.size() < DEPTH);
            if (!cpu_we && m_reg.size() > 0) begin
                void'(m_reg.pop_front());
                void'(m_data.pop_front());
            end
            m_dropped = m_acc && (req_reg == 5'd0);
            if (m_acc && req_reg != 5'd0) begin
                m_found = 0;
                foreach (m_reg[k]) begin
                    if (m_reg[k] == req_reg) begin
                        m_data[k] = req_data;
                        m_found   = 1;
                    end
                end
                if (!m_found) begin
                    m_reg.push_back(req_reg);
                    m_data.push_back(req_data);
                end
            end
            m_done = 1;
        end
    end

    // Compare process: inputs change at negedge, outputs are checked 2 time units later.
    always @(negedge clock) begin
        bit          e_inj;
        bit          e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        #2;
        if (m_valid) begin
            e_inj  = reset && !cpu_we && (m_reg.size() > 0);
            e_we   = cpu_we || e_inj;
            e_rd   = cpu_we ? cpu_rd : (e_inj ? 5'(m_reg[0]) : 5'd0);
            e_data = cpu_we ? cpu_data : (e_inj ? m_data[0] : 32'd0);
            chk("rf_we", 32'(rf_we), 32'(e_we));
            chk("rf_rd", 32'(rf_rd), 32'(e_rd));
            chk("rf_data", rf_data, e_data);
            chk("inj_active", 32'(inj_active), 32'(e_inj));
            chk("dropped", 32'(dropped), 32'(m_dropped));
            chk("count", 32'(count), 32'(m_reg.size()));
            chk("req_ready", 32'(req_ready), 32'(m_done && (m_reg.size() < DEPTH)));
        end
    end

    task automatic drive(input bit rst, input bit v, input logic [4:0] rr, input logic [31:0] rd,
                         input bit cwe, input logic [4:0] crd, input logic [31:0] cd);
        @(negedge clock);
        reset     = rst;
        req_valid = v;
        req_reg   = rr;
        req_data  = rd;
        cpu_we    = cwe;
        cpu_rd    = crd;
        cpu_data  = cd;
        #3;
    endtask

    initial begin
        logic [4:0]  w_reg;
        logic [31:0] w_val;
        int unsigned cwe_pct;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_reg   = '0;
        req_data  = '0;
        cpu_we    = 1'b1;
        cpu_rd    = 5'd3;
        cpu_data  = 32'd7;

        // Reset: outputs mirror the processor, queue idle.
        repeat (3) drive(0, 0, 0, 0, 1, 3, 7);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd3);
        chk("rst_rf_data", rf_data, 32'd7);
        chk("rst_inj", 32'(inj_active), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("ready_first_cycle", 32'(req_ready), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("ready_second_cycle", 32'(req_ready), 32'd1);

        // Basic inject.
        drive(1, 1, 5, 32'h1234, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("basic_rf_we", 32'(rf_we), 32'd1);
        chk("basic_rf_rd", 32'(rf_rd), 32'd5);
        chk("basic_rf_data", rf_data, 32'h1234);
        chk("basic_inj", 32'(inj_active), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("basic_count_after", 32'(count), 32'd0);

        // Processor priority and starvation.
        for (int i = 0; i < 4; i++) drive(1, 1, 5'(10 + i), 32'(100 + i), 1, 3, 7);
        drive(1, 0, 0, 0, 1, 3, 7);
        chk("starve_ready", 32'(req_ready), 32'd0);
        chk("starve_count", 32'(count), 32'd4);
        chk("starve_rf_rd", 32'(rf_rd), 32'd3);
        drive(1, 0, 0, 0, 1, 3, 7);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            chk("drain_rf_rd", 32'(rf_rd), 32'(10 + i));
            chk("drain_rf_data", rf_data, 32'(100 + i));
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(count), 32'd0);

        // Coalesce.
        drive(1, 1, 7, 1, 1, 3, 7);
        drive(1, 1, 8, 2, 1, 3, 7);
        drive(1, 1, 7, 3, 1, 3, 7);
        drive(1, 0, 0, 0, 1, 3, 7);
        chk("coalesce_count", 32'(count), 32'd2);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("coalesce_rd0", 32'(rf_rd), 32'd7);
        chk("coalesce_data0", rf_data, 32'd3);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("coalesce_rd1", 32'(rf_rd), 32'd8);
        chk("coalesce_data1", rf_data, 32'd2);
        drive(1, 0, 0, 0, 0, 0, 0);

        // r0 filter.
        drive(1, 1, 0, 99, 1, 3, 7);
        drive(1, 0, 0, 0, 1, 3, 7);
        chk("r0_dropped", 32'(dropped), 32'd1);
        chk("r0_count", 32'(count), 32'd0);
        drive(1, 0, 0, 0, 1, 3, 7);
        chk("r0_dropped_end", 32'(dropped), 32'd0);

        // Pointer wrap over push/drain rounds.
        for (int n = 0; n < 10; n++) begin
            w_reg = 5'(1 + n);
            w_val = $urandom;
            drive(1, 1, w_reg, w_val, 0, 0, 0);
            drive(1, 0, 0, 0, 0, 0, 0);
            chk("wrap_rf_rd", 32'(rf_rd), 32'(w_reg));
            chk("wrap_rf_data", rf_data, w_val);
        end

        // Reset mid-queue.
        drive(1, 1, 1, 11, 1, 3, 7);
        drive(1, 1, 2, 22, 1, 3, 7);
        drive(1, 1, 4, 44, 1, 3, 7);
        drive(0, 0, 0, 0, 1, 9, 32'h55);
        chk("midrst_rf_rd", 32'(rf_rd), 32'd9);
        chk("midrst_rf_data", rf_data, 32'h55);
        chk("midrst_inj", 32'(inj_active), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_no_stale", 32'(rf_we), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("midrst_ready_back", 32'(req_ready), 32'd1);
        chk("midrst_still_idle", 32'(rf_we), 32'd0);

        // Random traffic; processor load varies per block to hit both starvation and drain.
        cwe_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) cwe_pct = $urandom_range(10, 95);
            drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 6),
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < cwe_pct), 5'($urandom), $urandom);
        end

        @(negedge clock);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_reg_injector.md
# io_reg_injector

Write-side companion to the register-file test/read harness: where the harness hijacks a regfile read port to observe state, this block hijacks the regfile write port to inject externally produced values. Typical sources are paddle, button and score-reset logic in the pong datapath. The block queues injection requests in a small FIFO and sits between the processor's write port and the `regfile`. It drains the queue only on cycles where the processor is not writing, so processor writes are never delayed or lost.

## Interface

Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `CW`, default 3: width of `count`; must satisfy 2^CW > DEPTH.

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `req_valid`  in  1  injection request valid.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_reg`  in  5  target register number.
- `req_data`  in  32  value to write.
- `cpu_we`  in  1  processor `ctrl_writeEnable`.
- `cpu_rd`  in  5  processor `ctrl_writeReg`.
- `cpu_data`  in  32  processor `data_writeReg`.
- `rf_we`  out  1  to regfile `ctrl_writeEnable`.
- `rf_rd`  out  5  to regfile `ctrl_writeReg`.
- `rf_data`  out  32  to regfile `data_writeReg`.
- `inj_active`  out  1  high in a cycle where `rf_*` carries an injected write.
- `dropped`  out  1  one-cycle pulse: an accepted request targeted r0 and was discarded.
- `count`  out  CW  number of occupied FIFO entries.

## Operation

**Handshake**
- A request is accepted at a rising edge when `req_valid && req_ready`.
- `req_ready = (count < DEPTH) && reset_done`.
- `reset_done` is a flop: cleared by reset, set on the first edge with `reset` high.
- When full, `req_ready` stays low even if a pop occurs in the same cycle; there is no full-queue pass-through.

**r0 filter**
- An accepted request with `req_reg == 0` is not enqueued.
- `dropped` is registered high for the following cycle.

**Coalescing**
- An accepted request whose `req_reg` matches a queued entry overwrites that entry's data in place. No new entry is allocated and `count` is unchanged.
- If the only matching entry is the head being popped that same edge, a new tail entry is allocated instead.
- At most one entry per register can exist, so at most one match is possible.

**Write-port mux (combinational)**
- `cpu_we == 1`: `rf_we = 1`, `rf_rd = cpu_rd`, `rf_data = cpu_data`, `inj_active = 0`.
- `cpu_we == 0` and `count > 0`: `rf_we = 1`, `rf_rd` and `rf_data` come from the FIFO head, `inj_active = 1`; the head is popped at the edge.
- Otherwise: `rf_we = 0`, `rf_rd = 0`, `rf_data = 0`, `inj_active = 0`.

**Pointers and count**
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` changes per edge:
  - +1 on an allocating push,
  - −1 on a pop,
  - unchanged on both, on a coalesce-only push, or on neither.

**Ordering**
- Injected writes drain in FIFO order.
- A processor write to a register with a pending injection does not cancel it. The injection lands later and wins, which is the intended behavior.

**Reset mid-operation**
- The queue is flushed and pending injections are lost.
- `rf_*` continue to pass processor writes through while reset is asserted.

## Timing

- Latency: a request accepted at edge N can drive `rf_*` in cycle N+1, i.e. it is written by the regfile at edge N+1 if `cpu_we` is low in that cycle.
- Throughput: one injection per processor-idle cycle.
- Starvation: while `cpu_we` stays high, the queue does not drain; `req_ready` falls once `count` reaches DEPTH.
- Reset values: `count = 0`, `req_ready = 0`, `dropped = 0`, `inj_active = 0`, and `rf_*` mirror the `cpu_*` inputs. `req_ready` rises one cycle after `reset` deasserts.
- All outputs except `rf_*`, `inj_active` and `req_ready` are registered. The mux outputs are combinational from `cpu_*` and the FIFO head, with no path from `req_*` to `rf_*`.

## Test plan

- **Basic inject:** with `cpu_we = 0`, accept (r5, 0x1234) → in the next cycle `rf_we = 1`, `rf_rd = 5`, `rf_data = 0x1234`, `inj_active = 1`; the cycle after, `count = 0`.
- **Processor priority:** hold `cpu_we = 1` (r3 = 7) for 6 cycles while pushing r10..r13 (DEPTH = 4) → `rf_*` always equal the cpu values; `req_ready` is low after the 4th accept; after `cpu_we` drops, r10, r11, r12, r13 drain in order over 4 cycles.
- **Coalesce:** with `cpu_we = 1`, push (r7, 1), (r8, 2), (r7, 3) → `count = 2`; after release the writes are r7 = 3 then r8 = 2.
- **r0 and wrap:** push (r0, 99) → `dropped` pulses for 1 cycle and `count` stays 0. Then run 10 push/drain rounds → pointers wrap and every write matches its request.
- **Reset mid-queue:** with 3 entries queued, assert `reset` low for 1 edge → `count = 0` and `req_ready = 0`, followed by `req_ready = 1` one cycle after release; no stale injection appears, and cpu writes pass through during reset.
